afifo_rd_arbiter: RTL and testbench

Read-side arbiter that shares a single async FIFO read port among `NUM_REQ` requesters in the read clock domain. It grants one requester at a time using round-robin and runs a committed burst of `req_len` pops. It drives `rinc` from the FIFO's `rempty`/`rdata` handshake and returns registered data tagged with the owner ID. It sits between the FIFO read interface and the consumer blocks, and replaces ad-hoc per-consumer `rinc` driving.

---
 rtl/afifo_rd_arbiter_if.sv | 33 +++
 rtl/afifo_rd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_afifo_rd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_arbiter_if.sv
// Read-side bundle for afifo_rd_arbiter: requester side, consumer data return
// and the async FIFO read port. The arbiter uses the master modport.
interface afifo_rd_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     rd_valid;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [ID_W-1:0]          rd_id;
    logic                     rd_last;
    logic                     rd_abort;
    logic                     rempty;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     rinc;

    modport master (
        input  req, req_len, rempty, rdata,
        output gnt, done, rd_valid, rd_data, rd_id, rd_last, rd_abort, rinc
    );

    modport slave (
        output req, req_len, rempty, rdata,
        input  gnt, done, rd_valid, rd_data, rd_id, rd_last, rd_abort, rinc
    );
endinterface

// File: rtl/afifo_rd_arbiter.sv
// Round-robin arbiter sharing one async FIFO read port among NUM_REQ requesters
// with committed bursts. Define AFIFO_RD_ARB_TIMEOUT_EN to abort bursts stalled for TIMEOUT cycles.
module afifo_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 64
) (
    input logic                rclk,
    input logic                rrst_n,
    afifo_rd_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("afifo_rd_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        owner, owner_nxt;
    logic [ID_W-1:0]        last_id, last_id_nxt;
    logic [LEN_W-1:0]       remaining, remaining_nxt;
    logic [NUM_REQ-1:0]     gnt_q, gnt_nxt;
    logic [NUM_REQ-1:0]     done_q, done_nxt;
    logic                   last_q, last_nxt;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [ID_W-1:0]        id_q;

    logic                   found;
    logic [ID_W-1:0]        pick;
    logic [ID_W-1:0]        cand;
    logic [LEN_W-1:0]       raw_len;
    logic [LEN_W-1:0]       pick_len;
    logic                   pop;

    // Pop only while bursting with words left; drops with state on async reset.
    assign pop = (state == BURST) && !bus.rempty && (remaining != '0);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_id) + off) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        raw_len = bus.req_len[int'(pick)*LEN_W +: LEN_W];
        if (raw_len == '0) begin
            pick_len = LEN_W'(1);
        end else if (raw_len > LEN_W'(MAX_BURST)) begin
            pick_len = LEN_W'(MAX_BURST);
        end else begin
            pick_len = raw_len;
        end
    end

`ifdef AFIFO_RD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_hit;
    logic             abort_q, abort_nxt;

    // The TIMEOUT-th consecutive empty cycle of a burst ends it.
    assign stall_hit = (state == BURST) && bus.rempty && (stall_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= abort_nxt;
            if (state == BURST && bus.rempty && !stall_hit) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign bus.rd_abort = abort_q;
`else
    assign bus.rd_abort = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_id_nxt   = last_id;
        remaining_nxt = remaining;
        gnt_nxt       = gnt_q;
        done_nxt      = '0;
        last_nxt      = 1'b0;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
        abort_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = BURST;
                    owner_nxt     = pick;
                    remaining_nxt = pick_len;
                    gnt_nxt       = NUM_REQ'(1) << pick;
                end
            end
            BURST: begin
                if (pop) begin
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_nxt   = IDLE;
                        last_id_nxt = owner;
                        gnt_nxt     = '0;
                        done_nxt    = NUM_REQ'(1) << owner;
                        last_nxt    = 1'b1;
                    end
                end
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
                else if (stall_hit) begin
                    state_nxt     = IDLE;
                    last_id_nxt   = owner;
                    remaining_nxt = '0;
                    gnt_nxt       = '0;
                    done_nxt      = NUM_REQ'(1) << owner;
                    abort_nxt     = 1'b1;
                end
`endif
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            owner     <= '0;
            last_id   <= ID_W'(NUM_REQ - 1);
            remaining <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last_id   <= last_id_nxt;
            remaining <= remaining_nxt;
            gnt_q     <= gnt_nxt;
            done_q    <= done_nxt;
            last_q    <= last_nxt;
            valid_q   <= pop;
            if (pop) begin
                data_q <= bus.rdata;
                id_q   <= owner;
            end
        end
    end

    assign bus.rinc     = pop;
    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = valid_q;
    assign bus.rd_data  = data_q;
    assign bus.rd_id    = id_q;
    assign bus.rd_last  = last_q;
endmodule

// File: tb/tb_afifo_rd_arbiter.sv
// Scoreboard bench for afifo_rd_arbiter: a queue-based FIFO model feeds the DUT,
// a round-robin reference predicts (id, data, last) per word, a monitor compares.
module tb_afifo_rd_arbiter;
    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int MB    = 16;
    localparam int TO    = 64;
    localparam int LEN_W = $clog2(MB + 1);

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        bit          last;
    } exp_t;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    always #5 rclk = ~rclk;

    afifo_rd_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) bus ();

    afifo_rd_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO)
    ) dut (
        .rclk  (rclk),
        .rrst_n(rrst_n),
        .bus   (bus)
    );

    exp_t          sb[$];
    int            sb_rd = 0;
    logic [DW-1:0] words[$];
    logic [DW-1:0] fifo_q[$];
    int            feed_limit = 1 << 30;
    bit            feed_all = 1'b1;
    int            pop_count = 0;
    int            flush_req = 0;
    bit            mon_en = 1'b0;
    int            model_last = NR - 1;
    int            lens[NR];
    int            total = 0;
    int            bad = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // FIFO model: pops on rinc seen at the edge, then updates rempty/rdata 1 time unit later.
    initial begin
        int feed_idx = 0;
        int flush_ack = 0;
        bit do_pop;
        bus.rempty = 1'b1;
        bus.rdata  = '0;
        forever begin
            @(posedge rclk);
            do_pop = bus.rinc;
            #1;
            if (flush_req != flush_ack) begin
                fifo_q.delete();
                feed_idx  = words.size();
                flush_ack = flush_req;
                do_pop    = 1'b0;
            end
            if (do_pop) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pop_count++;
            end
            while (feed_idx < words.size() && feed_idx < feed_limit) begin
                if (!feed_all && $urandom_range(3) == 0) break;
                fifo_q.push_back(words[feed_idx]);
                feed_idx++;
                if (!feed_all) break;
            end
            bus.rempty = (fifo_q.size() == 0);
            bus.rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: compares every presented word against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge rclk);
            if (!rrst_n) begin
                sb_rd = sb.size();
            end else if (mon_en) begin
                check("rinc_safe", bus.rinc && (bus.rempty || bus.gnt == '0), 0);
                if (bus.rd_valid) begin
                    if (sb_rd >= sb.size()) begin
                        check("unexpected_word", bus.rd_valid, 0);
                    end else begin
                        e = sb[sb_rd];
                        sb_rd++;
                        check("rd_id", bus.rd_id, e.id);
                        check("rd_data", bus.rd_data, e.data);
                        check("rd_last", bus.rd_last, e.last);
                        check("done", bus.done, e.last ? (1 << e.id) : 0);
                        check("gnt", bus.gnt, e.last ? 0 : (1 << e.id));
                        check("rd_abort", bus.rd_abort, 0);
                    end
                end else begin
                    check("stray_last", bus.rd_last, 0);
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
                    check("stray_done", (bus.done != '0) && !bus.rd_abort, 0);
`else
                    check("stray_done", {bus.done, bus.rd_abort}, 0);
`endif
                end
            end
        end
    end

    // Reference: winners in cyclic order after the last owner; each takes the next clamped-length words.
    task automatic plan(input logic [NR-1:0] mask, output int n);
        int w;
        w = model_last;
        n = 0;
        for (int s = 1; s <= NR; s++) begin
            int i;
            int len;
            i = (model_last + s) % NR;
            if (mask[i]) begin
                len = (lens[i] == 0) ? 1 : ((lens[i] > MB) ? MB : lens[i]);
                for (int j = 0; j < len; j++) begin
                    logic [DW-1:0] d;
                    d = $urandom;
                    words.push_back(d);
                    sb.push_back('{id: i, data: d, last: (j == len - 1)});
                end
                n += len;
                w = i;
            end
        end
        model_last = w;
    endtask

    task automatic start(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
        bus.req = mask;
    endtask

    task automatic do_reset();
        #2;
        rrst_n = 1'b0;
        flush_req++;
        bus.req = '0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        model_last = NR - 1;
    endtask

    task automatic wait_done(input logic [NR-1:0] drop, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge rclk);
            for (int i = 0; i < NR; i++) begin
                if (bus.done[i] || (drop[i] && bus.rd_valid && bus.rd_id == i)) bus.req[i] = 1'b0;
            end
            if (bus.req == '0 && sb_rd == sb.size()) begin
                ok = 1'b1;
                break;
            end
        end
        check("bursts_finish", ok, 1);
        if (!ok) do_reset();
    endtask

    task automatic run(input logic [NR-1:0] mask, input logic [NR-1:0] drop);
        int n;
        int p0;
        p0 = pop_count;
        plan(mask, n);
        repeat (2) @(negedge rclk);
        start(mask);
        wait_done(drop, 3000);
        repeat (2) @(negedge rclk);
        check("pop_count", pop_count - p0, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int base;
        int seen;
        bus.req     = '0;
        bus.req_len = '0;
        repeat (3) @(negedge rclk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_data", bus.rd_data, 0);
        check("rst_id", bus.rd_id, 0);
        check("rst_last", bus.rd_last, 0);
        check("rst_abort", bus.rd_abort, 0);
        check("rst_rinc", bus.rinc, 0);
        rrst_n = 1'b1;
        mon_en = 1'b1;

        // Single 3-word burst from requester 0.
        feed_all = 1'b1;
        lens = '{3, 1, 1, 1};
        run(4'b0001, 4'b0000);

        // All four requesters, two words each, from reset: order 0,1,2,3.
        do_reset();
        lens = '{2, 2, 2, 2};
        run(4'b1111, 4'b0000);

        // FIFO runs dry after 2 of 5 words; rest arrives later.
        p0 = pop_count;
        base = words.size();
        feed_limit = base + 2;
        lens = '{5, 1, 1, 1};
        plan(4'b0001, n);
        repeat (2) @(negedge rclk);
        start(4'b0001);
        repeat (12) @(negedge rclk);
        check("stall_gnt", bus.gnt, 4'b0001);
        check("stall_rinc", bus.rinc, 0);
        check("stall_pops", pop_count - p0, 2);
        feed_limit = 1 << 30;
        wait_done(4'b0000, 500);
        repeat (2) @(negedge rclk);
        check("stall_total_pops", pop_count - p0, 5);

        // Length boundaries and mid-burst request drop.
        lens = '{1, 20, 0, 6};
        run(4'b0100, 4'b0000);
        run(4'b0010, 4'b0000);
        run(4'b1000, 4'b1000);

        // Reset in the middle of an 8-word burst.
        mon_en = 1'b0;
        lens = '{8, 1, 1, 1};
        for (int j = 0; j < 8; j++) words.push_back($urandom);
        repeat (2) @(negedge rclk);
        start(4'b0001);
        seen = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge rclk);
            if (bus.rd_valid) seen++;
        end
        check("pre_reset_words", seen, 3);
        #2;
        check("pre_reset_rinc", bus.rinc, 1);
        rrst_n = 1'b0;
        #1;
        check("reset_rinc", bus.rinc, 0);
        check("reset_gnt", bus.gnt, 0);
        check("reset_valid", bus.rd_valid, 0);
        flush_req++;
        bus.req = '0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        model_last = NR - 1;
        mon_en = 1'b1;
        lens = '{1, 1, 1, 1};
        run(4'b1111, 4'b0000);

        // Randomized masks, lengths, drops and FIFO fill rate.
        feed_all = 1'b0;
        repeat (20) begin
            for (int i = 0; i < NR; i++) lens[i] = $urandom_range(0, 20);
            run(NR'($urandom_range(1, 15)), NR'($urandom_range(0, 15)));
        end

`ifdef AFIFO_RD_ARB_TIMEOUT_EN
        begin
            int w;
            int cyc;
            bit hit;
            feed_all = 1'b1;
            lens = '{2, 2, 2, 2};
            feed_limit = words.size();
            w = ((model_last + 1) % NR == 1) ? 1 : 0;
            start(4'b0011);
            for (int c = 0; c < 20 && bus.gnt == '0; c++) @(negedge rclk);
            check("to_gnt", bus.gnt, 1 << w);
            cyc = 0;
            hit = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge rclk);
                cyc++;
                if (bus.rd_abort) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("to_abort_seen", hit, 1);
            check("to_abort_delay", cyc, TO);
            check("to_done", bus.done, 1 << w);
            check("to_valid", bus.rd_valid, 0);
            bus.req[w] = 1'b0;
            model_last = w;
            p0 = pop_count;
            plan(4'b0011 & ~(4'b0001 << w), n);
            feed_limit = 1 << 30;
            wait_done(4'b0000, 500);
            repeat (2) @(negedge rclk);
            check("to_next_pops", pop_count - p0, n);
        end
`endif

        repeat (5) @(negedge rclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
